dc_mem_responder: RTL

- Memory-side responder for the data cache's tiny AXI write and read buses.
- Accepts line write-back requests (128-bit data plus byte mask) and line fill requests from the cache miss engine.
- Services each request against an internal 1R1W 128-bit line RAM after a programmable latency.
- Returns a write-response pulse, or the read data with valid and finish pulses.

---
 rtl/dc_mem_responder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/dc_mem_responder.sv
// Memory-side responder for the data cache write/read buses: serialises line
// write-backs and line fills against an internal byte-enabled 128-bit line RAM.
module dc_mem_responder #(
    parameter int MWIDTH = 10,
    parameter int WR_LAT = 4,
    parameter int RD_LAT = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dcw_start_rq,
    input  logic [31:0]  dcw_in_addr,
    input  logic [15:0]  dcw_in_mask,
    input  logic [127:0] dcw_in_data,
    output logic         dcw_finish_wresp,
    input  logic         dcr_start_rq,
    input  logic [31:0]  dcr_rin_addr,
    input  logic         rqfull_1,
    output logic [127:0] rdat_m_data,
    output logic         rdat_m_valid,
    output logic         finish_mrd,
    output logic         req_ovf
);

    localparam int LINES = 1 << MWIDTH;

    typedef enum logic [2:0] {
        IDLE, WLAT, WRAM, WRSP, RLAT, RRAM, RDAT, RFIN
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_next;

    logic [MWIDTH-1:0]   r_idx;
    logic [15:0]         r_mask;
    logic [127:0]        r_data;

    logic                r_pw_valid;
    logic [MWIDTH-1:0]   r_pw_idx;
    logic [15:0]         r_pw_mask;
    logic [127:0]        r_pw_data;
    logic                r_pr_valid;
    logic [MWIDTH-1:0]   r_pr_idx;

    logic                r_ovf;
    logic [127:0]        r_rdata;
    logic [127:0]        r_mem [LINES];

    logic [MWIDTH-1:0]   w_wr_idx;
    logic [MWIDTH-1:0]   w_rd_idx;
    logic                w_take_pw;
    logic                w_take_pr;
    logic                w_take_nw;
    logic                w_take_nr;
    logic                w_wslot_free;
    logic                w_rslot_free;
    logic                w_store_w;
    logic                w_store_r;
    logic                w_drop;
    logic                w_unused_addr;

    assign w_wr_idx = dcw_in_addr[MWIDTH+3:4];
    assign w_rd_idx = dcr_rin_addr[MWIDTH+3:4];
    assign w_unused_addr = ^{dcw_in_addr[3:0], dcw_in_addr[31:MWIDTH+4],
                             dcr_rin_addr[3:0], dcr_rin_addr[31:MWIDTH+4]};

    // Only IDLE starts work; pending entries always outrank fresh requests.
    always_comb begin
        w_take_pw = 1'b0;
        w_take_pr = 1'b0;
        w_take_nw = 1'b0;
        w_take_nr = 1'b0;
        if (r_state == IDLE) begin
            if (r_pw_valid)        w_take_pw = 1'b1;
            else if (r_pr_valid)   w_take_pr = 1'b1;
            else if (dcw_start_rq) w_take_nw = 1'b1;
            else if (dcr_start_rq) w_take_nr = 1'b1;
        end
    end

    // A slot being drained this cycle may be refilled by a new arrival.
    assign w_wslot_free = !r_pw_valid || w_take_pw;
    assign w_rslot_free = !r_pr_valid || w_take_pr;
    assign w_store_w    = dcw_start_rq && !w_take_nw && w_wslot_free;
    assign w_store_r    = dcr_start_rq && !w_take_nr && w_rslot_free;
    assign w_drop       = (dcw_start_rq && !w_take_nw && !w_wslot_free) ||
                          (dcr_start_rq && !w_take_nr && !w_rslot_free);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_take_pw || w_take_nw) begin
                    w_next     = (WR_LAT == 1) ? WRAM : WLAT;
                    w_cnt_next = 8'(WR_LAT - 1);
                end else if (w_take_pr || w_take_nr) begin
                    w_next     = (RD_LAT == 1) ? RRAM : RLAT;
                    w_cnt_next = 8'(RD_LAT - 1);
                end
            end
            WLAT: begin
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt == 8'd1) w_next = WRAM;
            end
            WRAM: w_next = WRSP;
            WRSP: w_next = IDLE;
            RLAT: begin
                w_cnt_next = r_cnt - 8'd1;
                if (r_cnt == 8'd1) w_next = RRAM;
            end
            RRAM: w_next = RDAT;
            RDAT: if (!rqfull_1) w_next = RFIN;
            RFIN: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_idx      <= '0;
            r_mask     <= 16'd0;
            r_data     <= 128'd0;
            r_pw_valid <= 1'b0;
            r_pw_idx   <= '0;
            r_pw_mask  <= 16'd0;
            r_pw_data  <= 128'd0;
            r_pr_valid <= 1'b0;
            r_pr_idx   <= '0;
            r_ovf      <= 1'b0;
            r_rdata    <= 128'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;

            if (w_take_pw) begin
                r_idx  <= r_pw_idx;
                r_mask <= r_pw_mask;
                r_data <= r_pw_data;
            end else if (w_take_pr) begin
                r_idx <= r_pr_idx;
            end else if (w_take_nw) begin
                r_idx  <= w_wr_idx;
                r_mask <= dcw_in_mask;
                r_data <= dcw_in_data;
            end else if (w_take_nr) begin
                r_idx <= w_rd_idx;
            end

            if (w_store_w) begin
                r_pw_valid <= 1'b1;
                r_pw_idx   <= w_wr_idx;
                r_pw_mask  <= dcw_in_mask;
                r_pw_data  <= dcw_in_data;
            end else if (w_take_pw) begin
                r_pw_valid <= 1'b0;
            end

            if (w_store_r) begin
                r_pr_valid <= 1'b1;
                r_pr_idx   <= w_rd_idx;
            end else if (w_take_pr) begin
                r_pr_valid <= 1'b0;
            end

            if (w_drop) r_ovf <= 1'b1;

            if (r_state == RRAM) r_rdata <= r_mem[r_idx];
        end
    end

    // Byte-enable write: a set mask bit leaves that byte untouched.
    always_ff @(posedge clk) begin
        if (r_state == WRAM) begin
            for (int i = 0; i < 16; i++) begin
                if (!r_mask[i]) r_mem[r_idx][8*i +: 8] <= r_data[8*i +: 8];
            end
        end
    end

    assign dcw_finish_wresp = (r_state == WRSP);
    assign rdat_m_valid     = (r_state == RDAT) && !rqfull_1;
    assign finish_mrd       = (r_state == RFIN);
    assign rdat_m_data      = r_rdata;
    assign req_ovf          = r_ovf;

endmodule
